// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM client-port arbiter: FSM states and the client command payload.
package sdram_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // One client command as latched toward the SDRAM controller (word address, 1-based bit numbering)
    typedef struct packed {
        logic [ADDR_W:1]   addr;
        logic [DATA_W-1:0] wdata;
        logic              wrl;
        logic              wrh;
    } cmd_t;

    // Index width for a port count; never zero so a 1-bit index exists even for tiny configs
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after last_gnt+1, wrapping.
module rr_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned IDX_W   = idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_gnt_i,
    output logic [N_PORTS-1:0] gnt_c,
    output logic [IDX_W-1:0]   gnt_idx_c
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk ports in priority order starting just after the previous winner
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            cand = IDX_W'((32'(last_gnt_i) + i) % N_PORTS);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_c[cand] = 1'b1;
                gnt_idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multiplexes N client ports onto one 16-bit SDRAM controller port, one transaction at a time.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned N_PORTS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0][ADDR_W:1]    c_addr_i,
    input  logic [N_PORTS-1:0][DATA_W-1:0]  c_wdata_i,
    input  logic [N_PORTS-1:0]              c_wrl_i,
    input  logic [N_PORTS-1:0]              c_wrh_i,
    input  logic [N_PORTS-1:0]              c_req_i,
    output logic [N_PORTS-1:0]              c_ack_o,
    output logic [DATA_W-1:0]               c_rdata_o,
    output logic [ADDR_W:1]                 addr_o,
    output logic [DATA_W-1:0]               wdata_16o,
    output logic                            wrl_o,
    output logic                            wrh_o,
    output logic                            req_o,
    input  logic [DATA_W-1:0]               rdata_16i,
    input  logic                            ack_i,
    output logic                            busy_o
);

    localparam int unsigned IDX_W = idx_w(N_PORTS);

    state_t               state_q,    state_d;
    cmd_t                 cmd_q,      cmd_d;
    logic                 req_q,      req_d;
    logic [IDX_W-1:0]     gnt_q,      gnt_d;
    logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
    logic [N_PORTS-1:0]   c_ack_q,    c_ack_d;
    logic [DATA_W-1:0]    rdata_q,    rdata_d;
    logic                 busy_q,     busy_d;

    logic [N_PORTS-1:0]   arb_gnt_c;
    logic [IDX_W-1:0]     arb_idx_c;
    cmd_t                 sel_cmd_c;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i      (c_req_i),
        .last_gnt_i (last_gnt_q),
        .gnt_c      (arb_gnt_c),
        .gnt_idx_c  (arb_idx_c)
    );

    // One-hot mux of the winning client's command fields
    always_comb begin
        sel_cmd_c = '0;
        for (int p = 0; p < int'(N_PORTS); p++) begin
            if (arb_gnt_c[p]) begin
                sel_cmd_c.addr  = sel_cmd_c.addr  | c_addr_i[p];
                sel_cmd_c.wdata = sel_cmd_c.wdata | c_wdata_i[p];
                sel_cmd_c.wrl   = sel_cmd_c.wrl   | c_wrl_i[p];
                sel_cmd_c.wrh   = sel_cmd_c.wrh   | c_wrh_i[p];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        req_d      = req_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        c_ack_d    = '0;
        rdata_d    = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (|c_req_i) begin
                    cmd_d   = sel_cmd_c;
                    gnt_d   = arb_idx_c;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    rdata_d = rdata_16i;
                    req_d   = 1'b0;
                    c_ack_d = N_PORTS'(1) << gnt_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                last_gnt_d = gnt_q;
                state_d    = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            req_q      <= 1'b0;
            gnt_q      <= '0;
            last_gnt_q <= IDX_W'(N_PORTS - 1);
            c_ack_q    <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            req_q      <= req_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            c_ack_q    <= c_ack_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign addr_o    = cmd_q.addr;
    assign wdata_16o = cmd_q.wdata;
    assign wrl_o     = cmd_q.wrl;
    assign wrh_o     = cmd_q.wrh;
    assign req_o     = req_q;
    assign c_ack_o   = c_ack_q;
    assign c_rdata_o = rdata_q;
    assign busy_o    = busy_q;

endmodule
